// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg
// Shared definitions for the digit-serial adder/subtractor seq_adder_p:
//   - state_t  : control FSM states (IDLE, RUN, DONE)
//   - width_ok : elaboration-time check that WIDTH splits into whole digits
// No ports (package).
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when the operand width is an exact, non-zero multiple of the digit.
  function automatic bit width_ok(input int width, input int digit);
    return (digit > 0) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/seq_adder_p_adder_digit.sv
// adder_digit
// Combinational ripple of DIGIT 1-bit full adders; one digit slice of the
// serial adder.
// Ports:
//   a, b   [DIGIT-1:0] in  : digit operands
//   cin                in  : carry into bit 0
//   sum    [DIGIT-1:0] out : digit sum
//   cout               out : carry out of the top bit
//   c_msb              out : carry into the top bit (used for signed overflow)
module adder_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/seq_adder_p.sv
// seq_adder_p
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock,
// carry held in a register between digits. Valid/ready on both sides,
// one operation in flight at a time.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid / in_ready    : operand handshake (in_ready only in IDLE)
//   inp1, inp2 [WIDTH-1:0] : operands A, B
//   c_in                   : carry-in, add mode only
//   sub                    : 0 = A+B+c_in, 1 = A-B
//   out_valid / out_ready  : result handshake
//   s_out [WIDTH-1:0]      : sum/difference (modulo 2^WIDTH)
//   c_out                  : carry out of MSB (sub: 1 = no borrow)
//   ovf                    : signed overflow, present only when the
//                            macro SEQ_ADDER_OVF_EN is defined
module seq_adder_p
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s_out,
  output logic             c_out
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
    $error("seq_adder_p: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;

  logic [DIGIT-1:0] dig_a, dig_b, dig_sum;
  logic             dig_cout, dig_cmsb;
  int               idx;

  // Bit offset of the digit currently being processed.
  assign idx   = int'(cnt_q) * DIGIT;
  assign dig_a = a_q[idx +: DIGIT];
  assign dig_b = b_q[idx +: DIGIT];

  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (dig_a),
    .b     (dig_b),
    .cin   (carry_q),
    .sum   (dig_sum),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

`ifdef SEQ_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`else
  // Carry-into-MSB only feeds the overflow flag; nothing uses it here.
  logic unused_cmsb;
  assign unused_cmsb = dig_cmsb;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s_out     = sum_q;
  assign c_out     = c_out_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
`ifdef SEQ_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = inp1;
          // Subtraction as A + ~B + 1; c_in is ignored in that mode.
          b_d     = sub ? ~inp2 : inp2;
          carry_d = sub ? 1'b1 : c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx +: DIGIT] = dig_sum;
        carry_d             = dig_cout;
        if (cnt_q == LAST) begin
          c_out_d = dig_cout;
`ifdef SEQ_ADDER_OVF_EN
          ovf_d   = dig_cmsb ^ dig_cout;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
`ifdef SEQ_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_adder_p.sv
module tb_seq_adder_p;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inp1, inp2;
  logic             c_in, sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s_out;
  logic             c_out;
`ifdef SEQ_ADDER_OVF_EN
  logic             ovf;
`endif

  seq_adder_p #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp1      (inp1),
    .inp2      (inp2),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s_out     (s_out),
    .c_out     (c_out)
`ifdef SEQ_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: sampled on the falling edge; a handshake seen here completes at
  // the next rising edge, so the result is popped and compared now.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: s_out=%0h with empty scoreboard", s_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum", 32'(s_out), 32'(e.s));
        check("cout", 32'(c_out), 32'(e.c));
`ifdef SEQ_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(e.v));
`endif
        $display("result s_out=%h c_out=%0b (want %h/%0b)", s_out, c_out, e.s, e.c);
      end
    end
  end

  // Present operands until accepted; returns with in_valid dropped.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ci, input logic sb, input bit push,
                       input exp_t e);
    int n;
    @(posedge clk); #1;
    inp1 = a; inp2 = b; c_in = ci; sub = sb; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready=%0b want 1", in_ready);
    end
    @(posedge clk);
    if (push) exp_q.push_back(e);
    #1 in_valid = 1'b0;
    $display("issue a=%h b=%h c_in=%0b sub=%0b", a, b, ci, sb);
  endtask

  // Counts cycles from the accept edge until out_valid rises.
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(n), 32'(NDIG));
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic sb,
                        input logic [WIDTH-1:0] es, input logic ec, input logic ev);
    exp_t e;
    e.s = es; e.c = ec; e.v = ev;
    issue(a, b, ci, sb, 1'b1, e);
    wait_valid("latency");
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; inp1 = '0; inp2 = '0; c_in = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_s_out", 32'(s_out), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);

    //      a        b        c_in sub  sum      cout ovf
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure: result held in DONE while in_valid toggles.
    out_ready = 1'b0;
    e.s = 16'hBCDE; e.c = 1'b0; e.v = 1'b0;
    issue(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b1, e);
    wait_valid("bp_latency");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      inp1 = 16'h0F0F; inp2 = 16'h0101;
      @(negedge clk);
      check("bp_s_out", 32'(s_out), 32'h0000BCDE);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_no_extra_accept", 32'(exp_q.size()), 32'd0);

    // Reset after two RUN cycles abandons the operation.
    e.s = '0; e.c = 1'b0; e.v = 1'b0;
    issue(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0, e);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_s_out", 32'(s_out), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1 check("rst_mid_no_output", 32'(out_valid), 32'd0);

    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1 check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
